data_store_buffer: RTL and testbench
====================================

# data_store_buffer

Posted-write FIFO between the CPU memory-stage store port and the data memory write port. Stores retire into the buffer in one cycle and drain to data memory when the shared address path is free. Loads that hit a pending store's word either stall until that store drains or, when configured, are forwarded from the buffer. It lives inside `top`, between `riscv_cpu` and `data_mem`, and is gated by the data-memory address decode.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; fixed at 32 (4 byte lanes).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_wr_en` input 1: store request, already qualified by the data-memory decode.
- `cpu_wr_addr` input ADDR_WIDTH: store byte address.
- `cpu_wr_data` input 32: store data, already lane-aligned.
- `cpu_wr_be` input 4: store byte enables.
- `cpu_rd_en` input 1: load request, already qualified by the data-memory decode.
- `cpu_rd_addr` input ADDR_WIDTH: load byte address.
- `cpu_rd_word` input 1: the load is a full 32-bit LW.
- `buf_full_stall` output 1: the buffer is full; the CPU holds the store.
- `rd_hazard_stall` output 1: the load conflicts with a pending store; the CPU holds the load.
- `fwd_valid` output 1: `fwd_data` replaces the data-memory read data this cycle.
- `fwd_data` output 32: forwarded word.
- `mem_wr_en` output 1: drain strobe to `data_mem`.
- `mem_wr_addr` output ADDR_WIDTH: address of the head entry.
- `mem_wr_data` output 32: data of the head entry.
- `mem_wr_be` output 4: byte enables of the head entry.
- `mem_addr_sel_wr` output 1: steers the shared data-memory address mux to `mem_wr_addr`.

## Operation
- **Storage.** Circular FIFO: `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap naturally) and `count` (0..DEPTH). Each entry holds {valid, addr, data, be}.
- **Enqueue.**
  - When `cpu_wr_en` is high and `count < DEPTH` at the start of the cycle, the store is written at `wr_ptr`, which then increments.
  - When `count == DEPTH`, the store is ignored and `buf_full_stall` = 1. A drain in the same cycle does not admit it; the store enters on the next cycle.
- **Drain.**
  - `mem_wr_en` = (count ≠ 0) && (!`cpu_rd_en` || `rd_hazard_stall`).
  - The head fields drive `mem_wr_*` combinationally.
  - On the edge, the head entry is invalidated and `rd_ptr` increments.
  - `mem_addr_sel_wr` = `mem_wr_en`.
- **Hazard check.**
  - A load matches an entry when the entry is valid and `addr[ADDR_WIDTH-1:2]` equals `cpu_rd_addr[ADDR_WIDTH-1:2]`.
  - The store being enqueued in the same cycle is not compared.
  - With any match, and no forward granted, `rd_hazard_stall` = 1 and the drain proceeds, so the stall always resolves within `count` cycles.
- **Simultaneous events.**
  - Enqueue and drain in the same cycle leave `count` unchanged.
  - `cpu_wr_en` and `cpu_rd_en` are never both high from the CPU. If they are, the write is enqueued and the read is handled as above.
- **Width.** `count` is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

## Timing
- Reset (synchronous): `count`, pointers and all entry fields are 0, all valid bits are 0. Therefore every output reads 0 after reset.
- Reset mid-operation discards all pending stores; no drain is issued in the reset cycle.
- Store-to-drain latency: a store accepted at edge N can drain at the earliest in cycle N+1.
- Stalls and forwarding are combinational in the same cycle as the request. There is no added latency on the load path.
- Empty: `mem_wr_en` = 0.
- Full: `buf_full_stall` = 1 until a drain has completed on an earlier edge.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - Condition: a load with `cpu_rd_word` = 1 whose youngest matching entry has `be` = 4'b1111.
  - Response: `fwd_valid` = 1, `fwd_data` = that entry's data, `rd_hazard_stall` = 0, and the drain remains blocked by the read.
  - Any other match stalls.
- Undefined: `fwd_valid` and `fwd_data` are tied to 0, and every match stalls.

## Test plan
- **Basic drain.** Reset, then store 0xDEADBEEF to 0x10000010 with be=F, with no loads. Required: `mem_wr_en` pulses 1 cycle later with addr 0x10000010, data 0xDEADBEEF, be F; `count` returns to 0.
- **Fill and order.** Issue 5 back-to-back stores while `cpu_rd_en` is held high to an unrelated address. Required: 4 are accepted; the 5th sees `buf_full_stall` = 1. After the loads stop, drains occur in order 0..3, the 5th enters on the cycle after the first drain, and the pointers wrap.
- **Partial-store hazard.** Store SB be=4'b0100 to 0x10000020, then LW 0x10000022. Required: `rd_hazard_stall` = 1 for exactly one cycle while that entry drains, then 0; `fwd_valid` stays 0.
- **Forwarding (with `STORE_BUF_FWD_EN`).** Store 0x12345678 (be=F) to 0x10000030, then LW 0x10000030. Required: `fwd_valid` = 1 and `fwd_data` = 0x12345678 with no stall. Without the macro: one stall cycle, then `fwd_valid` = 0.
- **Simultaneous enqueue/drain.** With `count` = 2, store while the head drains. Required: `count` stays 2.
- **Reset mid-operation.** Assert `rst` with 3 entries pending. Required: next cycle `count` = 0, `mem_wr_en` = 0, and no write of the discarded entries ever appears.

Source files
------------

// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the CPU store port and data memory; stores drain when the
// shared address path is free. Optional load forwarding is enabled with `define STORE_BUF_FWD_EN.
module data_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_wr_en,
    input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    input  logic [3:0]            cpu_wr_be,
    input  logic                  cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    input  logic                  cpu_rd_word,
    output logic                  buf_full_stall,
    output logic                  rd_hazard_stall,
    output logic                  fwd_valid,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_wr_be,
    output logic                  mem_addr_sel_wr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [3:0]            be_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_s;
    logic             enq_s;
    logic             drain_s;
    logic             hit_s;
    logic [PTR_W-1:0] yng_s;
    logic [PTR_W-1:0] idx_s;
    logic             fwd_grant_s;

    assign full_s = (count_q == CNT_W'(DEPTH));
    assign enq_s  = cpu_wr_en && !full_s;

    // Word-address match against pending entries, walking oldest to youngest so the last hit wins
    always_comb begin
        hit_s = 1'b0;
        yng_s = '0;
        idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_q + PTR_W'(i);
            if (cpu_rd_en && valid_q[idx_s] &&
                (addr_q[idx_s][ADDR_WIDTH-1:2] == cpu_rd_addr[ADDR_WIDTH-1:2])) begin
                hit_s = 1'b1;
                yng_s = idx_s;
            end else begin
                hit_s = hit_s;
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    // Only a full-word load fully covered by the youngest matching store can be forwarded
    always_comb begin
        fwd_grant_s = 1'b0;
        if (cpu_rd_en && cpu_rd_word && hit_s && (be_q[yng_s] == 4'b1111)) begin
            fwd_grant_s = 1'b1;
        end else begin
            fwd_grant_s = 1'b0;
        end
    end
    assign fwd_valid = fwd_grant_s;
    assign fwd_data  = fwd_grant_s ? data_q[yng_s] : {DATA_WIDTH{1'b0}};

    logic unused_s;
    assign unused_s = ^cpu_rd_addr[1:0];
`else
    assign fwd_grant_s = 1'b0;
    assign fwd_valid   = 1'b0;
    assign fwd_data    = {DATA_WIDTH{1'b0}};

    logic unused_s;
    assign unused_s = ^{cpu_rd_addr[1:0], cpu_rd_word, yng_s};
`endif

    assign rd_hazard_stall = hit_s && !fwd_grant_s;
    assign buf_full_stall  = full_s;

    // A matching load keeps draining so its stall clears; an unrelated load owns the address path
    assign drain_s         = !rst && (count_q != '0) && (!cpu_rd_en || rd_hazard_stall);
    assign mem_wr_en       = drain_s;
    assign mem_addr_sel_wr = drain_s;
    assign mem_wr_addr     = addr_q[rd_ptr_q];
    assign mem_wr_data     = data_q[rd_ptr_q];
    assign mem_wr_be       = be_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (drain_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_s, drain_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; drain and enqueue never target the same slot in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= 4'b0000;
            end
        end else begin
            if (drain_s) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (enq_s) begin
                valid_q[wr_ptr_q] <= 1'b1;
                addr_q[wr_ptr_q]  <= cpu_wr_addr;
                data_q[wr_ptr_q]  <= cpu_wr_data;
                be_q[wr_ptr_q]    <= cpu_wr_be;
            end
        end
    end

endmodule

// File: tb/tb_data_store_buffer.sv
// Scoreboard bench for data_store_buffer: a queue-based store model predicts each cycle's
// outputs; a monitor compares them on the falling edge.
module tb_data_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_en;
    logic [31:0] cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic [3:0]  cpu_wr_be;
    logic        cpu_rd_en;
    logic [31:0] cpu_rd_addr;
    logic        cpu_rd_word;
    logic        buf_full_stall;
    logic        rd_hazard_stall;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        mem_addr_sel_wr;

    data_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_be(cpu_wr_be), .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_word(cpu_rd_word), .buf_full_stall(buf_full_stall),
        .rd_hazard_stall(rd_hazard_stall), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_addr_sel_wr(mem_addr_sel_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } st_t;

    typedef struct {
        logic        in_rst;
        logic        full;
        logic        haz;
        logic        fwd;
        logic [31:0] fdata;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] md;
        logic [3:0]  mbe;
    } exp_t;

    st_t  model_q[$];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One CPU cycle: drive inputs, predict outputs from pending stores, then advance the model
    task automatic cyc(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input logic re, input logic [31:0] ra,
                       input logic rw);
        exp_t e;
        int   yi;
        logic any;
        logic admit;
        @(posedge clk);
        #1;
        rst = r; cpu_wr_en = we; cpu_wr_addr = wa; cpu_wr_data = wd; cpu_wr_be = wbe;
        cpu_rd_en = re; cpu_rd_addr = ra; cpu_rd_word = rw;
        any = 1'b0;
        yi  = 0;
        if (re) begin
            foreach (model_q[i]) begin
                if (model_q[i].a[31:2] == ra[31:2]) begin
                    any = 1'b1;
                    yi  = i;
                end
            end
        end
        e.in_rst = r;
`ifdef STORE_BUF_FWD_EN
        e.fwd   = any && rw && (model_q[yi].be == 4'hF);
        e.fdata = e.fwd ? model_q[yi].d : 32'h0;
`else
        e.fwd   = 1'b0;
        e.fdata = 32'h0;
`endif
        e.haz  = any && !e.fwd;
        e.full = (model_q.size() == DEPTH);
        e.mwe  = !r && (model_q.size() != 0) && (!re || e.haz);
        e.ma   = (model_q.size() != 0) ? model_q[0].a  : 32'h0;
        e.md   = (model_q.size() != 0) ? model_q[0].d  : 32'h0;
        e.mbe  = (model_q.size() != 0) ? model_q[0].be : 4'h0;
        exp_q.push_back(e);
        if (r) begin
            model_q.delete();
        end else begin
            admit = we && (model_q.size() < DEPTH);
            if (e.mwe) void'(model_q.pop_front());
            if (admit) model_q.push_back('{a: wa, d: wd, be: wbe});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compares the DUT against each predicted cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, e.mwe});
                if (!e.in_rst) begin
                    chk("buf_full_stall", {31'h0, buf_full_stall}, {31'h0, e.full});
                    chk("rd_hazard_stall", {31'h0, rd_hazard_stall}, {31'h0, e.haz});
                    chk("fwd_valid", {31'h0, fwd_valid}, {31'h0, e.fwd});
                    chk("mem_addr_sel_wr", {31'h0, mem_addr_sel_wr}, {31'h0, e.mwe});
                    if (e.fwd) chk("fwd_data", fwd_data, e.fdata);
                    if (e.mwe) begin
                        chk("mem_wr_addr", mem_wr_addr, e.ma);
                        chk("mem_wr_data", mem_wr_data, e.md);
                        chk("mem_wr_be", {28'h0, mem_wr_be}, {28'h0, e.mbe});
                    end
                end
            end
        end
    end

    initial begin
        logic        we, re, rw, r;
        logic [31:0] a, ra, d;
        logic [3:0]  be;
        int          p;
        rst = 1'b1; cpu_wr_en = 1'b0; cpu_wr_addr = 32'h0; cpu_wr_data = 32'h0; cpu_wr_be = 4'h0;
        cpu_rd_en = 1'b0; cpu_rd_addr = 32'h0; cpu_rd_word = 1'b0;
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // Basic drain
        cyc(1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0);
        idle(3);

        // Fill behind unrelated loads, then hold the fifth store until it is admitted
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 32'h1000_0100 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF,
                1'b1, 32'h2000_0000, 1'b1);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 32'h1000_0110, 32'hA000_0004, 4'hF, (k < 2), 32'h2000_0000, 1'b1);
        idle(6);

        // Partial-store hazard
        cyc(1'b0, 1'b1, 32'h1000_0020, 32'h00AB_0000, 4'b0100, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000_0022, 1'b1);
        idle(2);

        // Full-word forward candidate
        cyc(1'b0, 1'b1, 32'h1000_0030, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000_0030, 1'b1);
        idle(3);

        // Simultaneous enqueue and drain at two entries
        cyc(1'b0, 1'b1, 32'h1000_0040, 32'h1111_1111, 4'hF, 1'b1, 32'h2000_0000, 1'b1);
        cyc(1'b0, 1'b1, 32'h1000_0044, 32'h2222_2222, 4'hF, 1'b1, 32'h2000_0000, 1'b1);
        cyc(1'b0, 1'b1, 32'h1000_0048, 32'h3333_3333, 4'h3, 1'b0, 32'h0, 1'b0);
        idle(4);

        // Reset with three pending stores
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, 32'h1000_0050 + 32'(k * 4), 32'h5550_0000 + 32'(k), 4'hF,
                1'b1, 32'h2000_0000, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        idle(4);

        // Randomized traffic over a small address window to provoke hits
        for (int n = 0; n < 3000; n++) begin
            p  = int'($urandom_range(0, 99));
            r  = (p == 0);
            we = (p >= 1) && (p <= 45);
            re = (p >= 40) && (p <= 80);
            a  = 32'h1000_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            ra = 32'h1000_0000 | (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
            d  = $urandom;
            be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
            rw = ($urandom_range(0, 3) != 0);
            cyc(r, we, a, d, be, re, ra, rw);
        end
        idle(8);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d predictions left, 0 expected", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
